gate_input_debouncer: RTL and testbench
=======================================

Name: gate_input_debouncer

Overview:
Upstream stage for the two-input gate block. Takes raw, asynchronous, bouncing board switch inputs for the A and B operands. Synchronises each input to the clock and debounces it, then presents clean, stable levels as the gate block's a/b operands. Also emits one-cycle change pulses and an overall "inputs settled" flag for downstream logging or LEDs.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each input synchroniser chain; legal range >= 2.
DEBOUNCE_CYCLES, 16, consecutive clock cycles a synchronised level must differ from the current output before the output is updated; legal range >= 2.

Ports:
clk_in  input  1  single system clock; all logic on its rising edge.
rst_n_in  input  1  reset, synchronous, active-low.
sw_a_in  input  1  raw asynchronous switch for operand A.
sw_b_in  input  1  raw asynchronous switch for operand B.
a_out  output  1  debounced operand A, feeds the gate block's a_in.
b_out  output  1  debounced operand B, feeds the gate block's b_in.
a_changed_out  output  1  one-cycle pulse on the cycle a_out takes a new value.
b_changed_out  output  1  one-cycle pulse on the cycle b_out takes a new value.
stable_out  output  1  high when neither channel is in COUNTING.

Behaviour:
- Clocking and reset: one clock, clk_in. Reset is synchronous and active-low on rst_n_in. All state is sampled only on the rising edge of clk_in.
- Reset values while rst_n_in is low at an edge:
  - sync chains, counters, a_out, b_out, a_changed_out and b_changed_out all go to 0;
  - both channel FSMs go to STABLE;
  - stable_out is 1.
- Channels are identical and fully independent. Description below is for channel A; channel B is the same.
- Synchroniser: sw_a_in passes through SYNC_STAGES flops; the last stage is the sample s.
- Counter: width is $clog2(DEBOUNCE_CYCLES+1). It never wraps, because it saturates by construction at DEBOUNCE_CYCLES-1.
- FSM states:
  - STABLE:
    - if s == a_out: stay; count = 0.
    - if s != a_out: go to COUNTING; count = 1.
  - COUNTING:
    - if s == a_out (bounce back): go to STABLE; count = 0; no pulse.
    - if s != a_out and count < DEBOUNCE_CYCLES-1: count++.
    - if s != a_out and count == DEBOUNCE_CYCLES-1: a_out <= s; a_changed_out <= 1 for exactly this one cycle; go to STABLE; count = 0.
- Latency: a clean level change on sw_a_in held steady reaches a_out on the (SYNC_STAGES + DEBOUNCE_CYCLES)th rising edge after the change. With defaults that is 18 edges.
- Outputs are registered. a_changed_out rises in the same cycle a_out changes.
- stable_out = (stateA == STABLE) && (stateB == STABLE). It is combinational from registered state, so glitch-free.
- Simultaneous changes on A and B are handled independently. Both pulses may assert in the same cycle.
- Reset mid-count: the in-progress count is discarded and outputs return to 0. After release, a held input needs the full latency again.
- A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never reaches the output.

Optional Feature:
GATE_DEB_BYPASS_EN:
- Defined:
  - debounce FSMs and counters are not compiled;
  - a_out/b_out equal the synchroniser outputs, so latency is SYNC_STAGES edges;
  - *_changed_out pulses for one cycle whenever the synchronised value differs from its previous-cycle value;
  - stable_out is tied to 1.
- Undefined: full debounce behaviour as above.

Decomposition:
- Package gate_deb_pkg holds:
  - state localparams STABLE = 1'b0, COUNTING = 1'b1;
  - default SYNC_STAGES and DEBOUNCE_CYCLES constants;
  - a counter-width function wrapping $clog2(DEBOUNCE_CYCLES+1).
- One natural sub-module, deb_channel: synchroniser, FSM, counter, level output and change pulse for one bit. It is instantiated twice.
- The top level only wires the two channels together and forms stable_out.

Test Plan:
Bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
1. Reset: hold rst_n_in=0 for 3 edges with sw_a_in=sw_b_in=1 -> a_out=b_out=0, both change pulses 0, stable_out=1 throughout.
2. Clean rise: sw_a_in 0->1 held -> a_out=1 on the 6th edge after the change, a_changed_out=1 for exactly that cycle, stable_out=0 on edges 3-5; b unaffected.
3. Bounce: sw_a_in high for 3 cycles, then low -> a_out stays 0, no a_changed_out pulse, stable_out returns to 1.
4. Simultaneous: sw_a_in and sw_b_in both 0->1 in the same cycle -> a_out and b_out both rise on edge 6, both pulses asserted in the same cycle; then a falls alone -> only a_changed_out pulses.
5. Reset mid-count: sw_a_in 0->1, assert rst_n_in=0 at edge 4, release at edge 5 -> a_out=0; a_out rises 6 edges after release.
6. With GATE_DEB_BYPASS_EN defined: sw_b_in 0->1 -> b_out=1 on edge 2 with a one-cycle b_changed_out; stable_out constantly 1.

Source files
------------

// File: rtl/gate_deb_pkg.sv
// Shared definitions for the gate input debouncer: channel state encoding,
// default sizing constants and the counter-width helper.
package gate_deb_pkg;

    // Per-channel debounce state
    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } deb_state_e;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    // Counter only reaches cycles-1, so this width always leaves headroom
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/deb_channel.sv
// One debounce channel: synchroniser chain, debounce FSM/counter, registered
// level output and one-cycle change pulse.
// Build option GATE_DEB_BYPASS_EN: drops the FSM/counter, the level follows the
// synchroniser directly and the pulse marks any synchronised transition.
module deb_channel
    import gate_deb_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic sw_in,
    output logic level_out,
    output logic changed_out,
    output logic counting_out
);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   s;

    // Synchroniser shift register; bit 0 takes the raw asynchronous input
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) sync_pipe <= '0;
        else           sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sw_in};
    end

    assign s = sync_pipe[SYNC_STAGES-1];

`ifdef GATE_DEB_BYPASS_EN

    logic changed_q;

    // Pulse when the value about to shift into the last stage differs from it
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) changed_q <= 1'b0;
        else           changed_q <= sync_pipe[SYNC_STAGES-2] ^ sync_pipe[SYNC_STAGES-1];
    end

    assign level_out    = s;
    assign changed_out  = changed_q;
    assign counting_out = 1'b0;

`else

    localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    deb_state_e    state;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          changed_q;

    // Debounce FSM: the level only moves after DEBOUNCE_CYCLES consecutive
    // differing samples; any sample matching the level restarts the wait
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state     <= STABLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            case (state)
                STABLE: begin
                    if (s != level_q) begin
                        state <= COUNTING;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                COUNTING: begin
                    if (s == level_q) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        level_q   <= s;
                        changed_q <= 1'b1;
                        state     <= STABLE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign level_out    = level_q;
    assign changed_out  = changed_q;
    assign counting_out = (state == COUNTING);

`endif

endmodule

// File: rtl/gate_input_debouncer.sv
// Debounces the A/B board switches feeding the two-input gate block and
// reports change pulses plus an overall settled flag.
// Build option GATE_DEB_BYPASS_EN: synchronise only, no debounce; settled flag
// is then constantly high.
module gate_input_debouncer
    import gate_deb_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic sw_a_in,
    input  logic sw_b_in,
    output logic a_out,
    output logic b_out,
    output logic a_changed_out,
    output logic b_changed_out,
    output logic stable_out
);

    localparam int NUM_CH = 2;

    logic [NUM_CH-1:0] sw, lvl, chg, cnting;

    assign sw = {sw_b_in, sw_a_in};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        deb_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_in       (clk_in),
            .rst_n_in     (rst_n_in),
            .sw_in        (sw[i]),
            .level_out    (lvl[i]),
            .changed_out  (chg[i]),
            .counting_out (cnting[i])
        );
    end

    assign a_out         = lvl[0];
    assign b_out         = lvl[1];
    assign a_changed_out = chg[0];
    assign b_changed_out = chg[1];
    // Built from registered channel states only, so it cannot glitch
    assign stable_out    = ~|cnting;

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Self-checking bench for gate_input_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Reference model works on per-edge history arrays: a level flips once the last
// DEBOUNCE_CYCLES synchronised samples all disagree with it.
module tb_gate_input_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int MAXE = 4096;

    logic clk_in = 1'b0;
    logic rst_n_in, sw_a_in, sw_b_in;
    logic a_out, b_out, a_changed_out, b_changed_out, stable_out;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_n = 0;

    // history per edge index: raw input, reset, sync output, model outputs
    logic raw [2][MAXE];
    logic sy  [2][MAXE];
    logic mo  [2][MAXE];
    logic mc  [2][MAXE];
    logic mct [2][MAXE];
    logic rh  [MAXE];

    typedef struct {
        logic rn, a, b;
        logic ea, eb, eca, ecb, est;
    } vec_t;
    vec_t tbl[$];

    always #5 clk_in = ~clk_in;

    gate_input_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .sw_a_in       (sw_a_in),
        .sw_b_in       (sw_b_in),
        .a_out         (a_out),
        .b_out         (b_out),
        .a_changed_out (a_changed_out),
        .b_changed_out (b_changed_out),
        .stable_out    (stable_out)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %b expected %b", nm, edge_n, act, exp);
        end
    endtask

    // Reference model for the edge just taken
    task automatic model_edge(input int e);
        for (int ch = 0; ch < 2; ch++) begin
            int   src;
            logic v, prev_out, prev_sy, flip;
            src = e - SYNC + 1;
            if (src < 0) v = 1'b0;
            else begin
                v = raw[ch][src];
                for (int k = src; k <= e; k++) if (rh[k]) v = 1'b0;
            end
            sy[ch][e] = v;
            prev_out  = (e > 0) ? mo[ch][e-1] : 1'b0;
            prev_sy   = (e > 0) ? sy[ch][e-1] : 1'b0;
`ifdef GATE_DEB_BYPASS_EN
            mo[ch][e]  = v;
            mc[ch][e]  = !rh[e] && (v != prev_sy);
            mct[ch][e] = 1'b0;
`else
            if (rh[e]) begin
                mo[ch][e] = 1'b0; mc[ch][e] = 1'b0; mct[ch][e] = 1'b0;
            end else begin
                flip = (e >= DEB);
                for (int j = 1; j <= DEB; j++)
                    if (e - j < 0 || sy[ch][e-j] == prev_out) flip = 1'b0;
                for (int k = e - DEB + 1; k < e; k++)
                    if (k >= 0 && rh[k]) flip = 1'b0;
                mo[ch][e]  = flip ? ~prev_out : prev_out;
                mc[ch][e]  = flip;
                mct[ch][e] = !flip && (prev_sy != prev_out);
            end
`endif
        end
    endtask

    // Apply inputs, take one edge, compare everything against the model
    task automatic tick(input logic rn, input logic a, input logic b);
        rst_n_in = rn; sw_a_in = a; sw_b_in = b;
        raw[0][edge_n] = a; raw[1][edge_n] = b; rh[edge_n] = !rn;
        @(posedge clk_in);
        #1;
        model_edge(edge_n);
        chk("model_a",  a_out,         mo[0][edge_n]);
        chk("model_b",  b_out,         mo[1][edge_n]);
        chk("model_ca", a_changed_out, mc[0][edge_n]);
        chk("model_cb", b_changed_out, mc[1][edge_n]);
        chk("model_st", stable_out,    !(mct[0][edge_n] || mct[1][edge_n]));
        edge_n++;
    endtask

    task automatic add(input logic rn, a, b, ea, eb, eca, ecb, est, input int n);
        for (int i = 0; i < n; i++) tbl.push_back('{rn, a, b, ea, eb, eca, ecb, est});
    endtask

    initial begin
        int ha, hb;
        logic va, vb, rn;

`ifndef GATE_DEB_BYPASS_EN
        // reset, settle, clean rise of A, clean fall of A
        add(0, 1, 1, 0, 0, 0, 0, 1, 3);
        add(1, 0, 0, 0, 0, 0, 0, 1, 4);
        add(1, 1, 0, 0, 0, 0, 0, 1, 2);
        add(1, 1, 0, 0, 0, 0, 0, 0, 3);
        add(1, 1, 0, 1, 0, 1, 0, 1, 1);
        add(1, 1, 0, 1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 1, 0, 0, 0, 1, 2);
        add(1, 0, 0, 1, 0, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1, 2);
        foreach (tbl[i]) begin
            tick(tbl[i].rn, tbl[i].a, tbl[i].b);
            chk("tbl_a",  a_out,         tbl[i].ea);
            chk("tbl_b",  b_out,         tbl[i].eb);
            chk("tbl_ca", a_changed_out, tbl[i].eca);
            chk("tbl_cb", b_changed_out, tbl[i].ecb);
            chk("tbl_st", stable_out,    tbl[i].est);
        end

        // bounce: 3 high cycles are too short to pass
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0);
            chk("bounce_a", a_out, 1'b0); chk("bounce_ca", a_changed_out, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1, 0, 0);
            chk("bounce_a", a_out, 1'b0); chk("bounce_ca", a_changed_out, 1'b0);
        end
        chk("bounce_st", stable_out, 1'b1);

        // simultaneous rise, then A falls alone
        for (int i = 1; i <= 6; i++) begin
            tick(1, 1, 1);
            chk("simul_a", a_out, i == 6); chk("simul_b", b_out, i == 6);
            chk("simul_ca", a_changed_out, i == 6); chk("simul_cb", b_changed_out, i == 6);
        end
        for (int i = 1; i <= 6; i++) begin
            tick(1, 0, 1);
            chk("afall_ca", a_changed_out, i == 6); chk("afall_cb", b_changed_out, 1'b0);
            chk("afall_b", b_out, 1'b1);
        end
        chk("afall_a", a_out, 1'b0);
        for (int i = 0; i < 6; i++) tick(1, 0, 0);
        chk("bfall_b", b_out, 1'b0);

        // reset mid-count, full latency needed after release
        for (int i = 0; i < 3; i++) tick(1, 1, 0);
        tick(0, 1, 0);
        chk("midrst_a", a_out, 1'b0); chk("midrst_st", stable_out, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            tick(1, 1, 0);
            chk("postrst_a", a_out, i == 6); chk("postrst_ca", a_changed_out, i == 6);
        end
        for (int i = 0; i < 6; i++) tick(1, 0, 0);
`else
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        tick(1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            tick(1, 0, 1);
            chk("byp_b", b_out, i >= 2); chk("byp_cb", b_changed_out, i == 2);
            chk("byp_st", stable_out, 1'b1);
        end
`endif

        // randomized bursts with occasional reset, model-checked every edge
        ha = 0; hb = 0; va = 0; vb = 0;
        for (int i = 0; i < 2000; i++) begin
            if (ha == 0) begin va = 1'($urandom_range(0, 1)); ha = $urandom_range(1, 8); end
            if (hb == 0) begin vb = 1'($urandom_range(0, 1)); hb = $urandom_range(1, 8); end
            ha--; hb--;
            rn = ($urandom_range(0, 199) != 0);
            tick(rn, va, vb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
